// File: rtl/serial_1011_frame_transmitter.sv
// Serial frame transmitter: preamble 1011, DATA_W-bit payload MSB first, and an
// optional even-parity bit enabled by defining SERIAL_TX_PARITY_EN.
module serial_1011_frame_transmitter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              o,
    output logic              o_valid,
    output logic              done,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);
`ifdef SERIAL_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // A one-bit payload is also the final frame bit when there is no parity.
    localparam bit ONE_BIT_LAST = (DATA_W == 1) && !PAR_EN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
`ifdef SERIAL_TX_PARITY_EN
        S_PAR,
`endif
        S_DATA
    } state_t;

    state_t            state_q;
    logic [1:0]        pre_idx_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] shift_q;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q;
`endif
    logic              o_q;
    logic              o_valid_q;
    logic              done_q;

    function automatic logic pre_bit(input logic [1:0] idx);
        logic b;
        case (idx)
            2'd0:    b = 1'b1;
            2'd1:    b = 1'b0;
            default: b = 1'b1;
        endcase
        return b;
    endfunction

    assign in_ready = (state_q == S_IDLE) && !rst;
    assign busy     = !in_ready;
    assign o        = o_q;
    assign o_valid  = o_valid_q;
    assign done     = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pre_idx_q <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
            o_q       <= 1'b0;
            o_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    o_q       <= 1'b0;
                    o_valid_q <= 1'b0;
                    done_q    <= 1'b0;
                    if (in_valid && in_ready) begin
                        shift_q   <= in_data;
`ifdef SERIAL_TX_PARITY_EN
                        par_q     <= ^in_data;
`endif
                        pre_idx_q <= '0;
                        cnt_q     <= '0;
                        o_q       <= pre_bit(2'd0);
                        o_valid_q <= 1'b1;
                        state_q   <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (pre_idx_q == 2'd3) begin
                        o_q       <= shift_q[DATA_W-1];
                        shift_q   <= shift_q << 1;
                        cnt_q     <= '0;
                        pre_idx_q <= '0;
                        done_q    <= ONE_BIT_LAST;
                        state_q   <= S_DATA;
                    end else begin
                        pre_idx_q <= pre_idx_q + 2'd1;
                        o_q       <= pre_bit(pre_idx_q + 2'd1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
                        o_q       <= par_q;
                        done_q    <= 1'b1;
                        state_q   <= S_PAR;
`else
                        o_q       <= 1'b0;
                        o_valid_q <= 1'b0;
                        done_q    <= 1'b0;
                        state_q   <= S_IDLE;
`endif
                    end else begin
                        o_q     <= shift_q[DATA_W-1];
                        shift_q <= shift_q << 1;
                        cnt_q   <= cnt_q + 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                        done_q  <= 1'b0;
`else
                        done_q  <= (cnt_q + 1'b1) == LAST_IDX;
`endif
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                S_PAR: begin
                    o_q       <= 1'b0;
                    o_valid_q <= 1'b0;
                    done_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
`endif
                default: begin
                    o_q       <= 1'b0;
                    o_valid_q <= 1'b0;
                    done_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    a_done_has_valid: assert property (@(posedge clk) disable iff (rst) done_q |-> o_valid_q);
    a_idle_quiet:     assert property (@(posedge clk) disable iff (rst)
                                       (state_q == S_IDLE) |-> (!o_valid_q || o_q));

endmodule

// File: tb/tb_serial_1011_frame_transmitter.sv
// Directed bench for serial_1011_frame_transmitter (8-bit, 4-bit loopback, 1-bit),
// covering both builds of SERIAL_TX_PARITY_EN.
module tb_serial_1011_frame_transmitter;

`ifdef SERIAL_TX_PARITY_EN
    localparam int L8 = 13;
    localparam int L4 = 9;
    localparam int L1 = 6;
    localparam logic [15:0] VA5 = {3'b0, 12'b1011_1010_0101, 1'b0};
    localparam logic [15:0] V07 = {3'b0, 12'b1011_0000_0111, 1'b1};
    localparam logic [15:0] VFF = {3'b0, 12'b1011_1111_1111, 1'b0};
    localparam logic [15:0] V00 = {3'b0, 12'b1011_0000_0000, 1'b0};
    localparam logic [15:0] V3C = {3'b0, 12'b1011_0011_1100, 1'b0};
    localparam logic [15:0] V1  = {10'b0, 6'b101111};
`else
    localparam int L8 = 12;
    localparam int L4 = 8;
    localparam int L1 = 5;
    localparam logic [15:0] VA5 = {4'b0, 12'b1011_1010_0101};
    localparam logic [15:0] V07 = {4'b0, 12'b1011_0000_0111};
    localparam logic [15:0] VFF = {4'b0, 12'b1011_1111_1111};
    localparam logic [15:0] V00 = {4'b0, 12'b1011_0000_0000};
    localparam logic [15:0] V3C = {4'b0, 12'b1011_0011_1100};
    localparam logic [15:0] V1  = {11'b0, 5'b10111};
`endif

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, o, o_valid, done, busy;
    logic [7:0] in_data;
    logic v4, r4, o4, ov4, dn4, b4;
    logic [3:0] d4;
    logic v1, r1, o1, ov1, dn1, b1;
    logic [0:0] d1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_1011_frame_transmitter #(.DATA_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .o(o), .o_valid(o_valid), .done(done), .busy(busy)
    );

    serial_1011_frame_transmitter #(.DATA_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_ready(r4),
        .o(o4), .o_valid(ov4), .done(dn4), .busy(b4)
    );

    serial_1011_frame_transmitter #(.DATA_W(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_ready(r1),
        .o(o1), .o_valid(ov1), .done(dn1), .busy(b1)
    );

    // Reference 1011 detector on the 4-bit loopback stream, fed only valid bits.
    logic [3:0] det_sh;
    int det_pos, hits, hit_pos;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            det_sh  <= '0;
            det_pos <= 0;
            hits    <= 0;
            hit_pos <= -1;
        end else if (ov4) begin
            det_sh  <= {det_sh[2:0], o4};
            det_pos <= det_pos + 1;
            if ({det_sh[2:0], o4} == 4'b1011) begin
                hits    <= hits + 1;
                hit_pos <= det_pos;
            end
        end else begin
            det_pos <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
    endtask

    task automatic expect_bits(input logic [15:0] bits, input int len, input string tag);
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s_o%0d", tag, i), 32'(o), 32'(bits[len-1-i]));
            check($sformatf("%s_v%0d", tag, i), 32'(o_valid), 32'd1);
            check($sformatf("%s_d%0d", tag, i), 32'(done), (i == len - 1) ? 32'd1 : 32'd0);
            check($sformatf("%s_b%0d", tag, i), 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        check({tag, "_idle_v"}, 32'(o_valid), 32'd0);
        check({tag, "_idle_d"}, 32'(done), 32'd0);
        check({tag, "_idle_o"}, 32'(o), 32'd0);
        check({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic tx_frame(input logic [7:0] d, input logic [15:0] bits, input int len,
                            input string tag);
        @(negedge clk);
        start(d);
        expect_bits(bits, len, tag);
    endtask

    initial begin
        int saw_done;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0;
        v4 = 1'b0; d4 = '0;
        v1 = 1'b0; d1 = '0;
        #1;
        check("rst_o", 32'(o), 32'd0);
        check("rst_v", 32'(o_valid), 32'd0);
        check("rst_d", 32'(done), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_rdy", 32'(in_ready), 32'd1);
        check("rel_busy", 32'(busy), 32'd0);

        tx_frame(8'hA5, VA5, L8, "a5");
        tx_frame(8'h07, V07, L8, "07");

        // Back-to-back with in_valid held; in_data changes under frame 1.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk);
        #1;
        in_data = 8'h00;
        expect_bits(VFF, L8, "ff");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expect_bits(V00, L8, "b2b00");

        // Reset at payload bit 3 of a frame.
        @(negedge clk);
        start(8'h5A);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check("mid_v", 32'(o_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_o", 32'(o), 32'd0);
        check("abort_v", 32'(o_valid), 32'd0);
        check("abort_d", 32'(done), 32'd0);
        check("abort_rdy", 32'(in_ready), 32'd0);
        saw_done = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            saw_done += int'(done) + int'(o_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        start(8'h3C);
        check("abort_no_done", 32'(saw_done), 32'd0);
        expect_bits(V3C, L8, "3c");

        // Loopback: two 4-bit frames of 0000 through the reference detector.
        @(negedge clk);
        v4 = 1'b1;
        d4 = 4'b0000;
        @(posedge clk);
        repeat (L4) @(posedge clk);
        @(posedge clk);
        #1;
        v4 = 1'b0;
        repeat (L4 + 3) @(posedge clk);
        #1;
        check("lb_hits", 32'(hits), 32'd2);
        check("lb_pos", 32'(hit_pos), 32'd3);

        // DATA_W=1: single-cycle payload.
        @(negedge clk);
        v1 = 1'b1;
        d1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        for (int i = 0; i < L1; i++) begin
            check($sformatf("w1_o%0d", i), 32'(o1), 32'(V1[L1-1-i]));
            check($sformatf("w1_v%0d", i), 32'(ov1), 32'd1);
            check($sformatf("w1_d%0d", i), 32'(dn1), (i == L1 - 1) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        check("w1_idle_v", 32'(ov1), 32'd0);
        check("w1_idle_rdy", 32'(r1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_1011_frame_transmitter.md
# serial_1011_frame_transmitter

Serial frame transmitter that produces the bit stream the `1011` sequence detector consumes. Each frame is the fixed preamble `1011` followed by a DATA_W-bit payload sent MSB first, plus an optional even-parity bit. A parallel word is accepted over a valid/ready handshake and shifted out one bit per clock with a qualifying valid strobe. The block sits on the transmit side of the serial link, and its output drives a detector instance directly in loopback benches.

## Interface
Parameters:
- `DATA_W`, default 8: payload width in bits; legal range ≥ 1.

Ports:
- `clk`  input  1: single clock; all state changes on its rising edge.
- `rst`  input  1: reset, asynchronous and active-high.
- `in_valid`  input  1: `in_data` holds a word to send.
- `in_data`  input  DATA_W: payload word; sampled only on the accept edge.
- `in_ready`  output  1: block can accept a word.
- `o`  output  1: serial bit, registered.
- `o_valid`  output  1: `o` carries a frame bit this cycle, registered.
- `done`  output  1: one-cycle pulse coincident with the last bit of a frame, registered.
- `busy`  output  1: frame in progress; equals `!in_ready`.

## Operation
- Reset (asynchronous, while `rst`=1):
  - State goes to IDLE.
  - `o`=0, `o_valid`=0, `done`=0.
  - Shift register and bit counter are cleared.
  - `in_ready`=0 while `rst` is asserted.
- `in_ready` = (state==IDLE) && !rst, combinational.
- Accept: rising edge with `in_valid` && `in_ready`.
  - `in_data` is latched into the shift register.
  - On the same edge, the first preamble bit is driven (`o`=1, `o_valid`=1) and the state moves to PRE.
- States:
  - IDLE: `o`=0, `o_valid`=0. Stays in IDLE until accept.
  - PRE: emits preamble bits 1,0,1,1, one per cycle; a 2-bit index counts 0..3. After index 3, moves to DATA.
  - DATA: emits the shift-register MSB each cycle and shifts left. The counter runs 0..DATA_W-1.
    - After the last payload bit, moves to PAR if parity is compiled in, otherwise to IDLE.
  - PAR (only when parity is compiled in): emits one even-parity bit, then moves to IDLE.
- `done`=1 on the same cycle as the final frame bit (last payload bit, or the parity bit).
- `in_valid` and `in_data` are ignored outside IDLE; changing `in_data` mid-frame has no effect on the stream.
- The bit counter is sized as $clog2(DATA_W+1). It must not wrap within a frame for any legal DATA_W.
- DATA_W=1: the payload phase is exactly one cycle.

## Timing
- Latency: the accept edge drives the first preamble bit; it is visible in the cycle after that edge.
- Frame length: L = 4 + DATA_W (+1 with parity). `o_valid` is high for exactly L consecutive cycles.
- After the final bit, the block spends one mandatory IDLE cycle with `o_valid`=0.
  - `in_ready` goes high in that cycle, so the minimum accept-to-accept spacing is L+1 cycles.
- Holding `in_valid` high continuously sends back-to-back frames separated by one idle bit (0).
- Reset asserted mid-frame: the frame is aborted immediately and outputs take their reset values. No `done` pulse is generated. The first accept is possible on the first edge after `rst` deasserts.

## Configuration
- Macro `SERIAL_TX_PARITY_EN`:
  - Defined: the PAR state exists, and an even-parity bit (XOR of all payload bits) is appended. L = DATA_W+5.
  - Undefined: there is no PAR state. `done` coincides with the last payload bit, and L = DATA_W+4.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle -> `o`=0, `o_valid`=0, `done`=0, `in_ready`=0 immediately. After release, `in_ready`=1.
- Single frame, DATA_W=8, `in_data`=8'hA5, parity disabled -> `o` = 1,0,1,1,1,0,1,0,0,1,0,1 over 12 cycles with `o_valid`=1. `done` is high on the 12th bit, followed by one cycle with `o_valid`=0.
- Parity enabled, data 8'hA5 -> same 12 bits, then parity bit 0. With data 8'h07 -> parity bit 1, and `done` on the 13th bit.
- Continuous `in_valid` with data 8'hFF then 8'h00 -> two frames separated by exactly one `o_valid`=0 cycle. `in_data` changes during frame 1 do not alter it.
- `rst` pulse at payload bit 3 -> no `done` pulse. A new accept of 8'h3C afterwards emits a clean full frame 1,0,1,1,0,0,1,1,1,1,0,0.
- Loopback into the `1011` detector with DATA_W=4, data 4'b0000 -> the detector flags exactly once per frame (at the 4th preamble bit).
